// File: rtl/mem_lsu_pkg.sv
// Shared definitions for the load/store unit: memop encodings, FSM states,
// byte-lane select constants and small decode helpers.
package mem_lsu_pkg;

   typedef enum logic [3:0] {
      MemNone = 4'd0,
      MemLb   = 4'd1,
      MemLbu  = 4'd2,
      MemLh   = 4'd3,
      MemLhu  = 4'd4,
      MemLw   = 4'd5,
      MemSb   = 4'd6,
      MemSh   = 4'd7,
      MemSw   = 4'd8
   } memop_e;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StBusy = 2'd1,
      StDone = 2'd2
   } lsu_state_e;

   // Big-endian: byte offset 0 lives in bits [31:24].
   localparam logic [3:0] SelByte0  = 4'b1000;
   localparam logic [3:0] SelHalfHi = 4'b1100;
   localparam logic [3:0] SelHalfLo = 4'b0011;
   localparam logic [3:0] SelWord   = 4'b1111;

   function automatic logic is_store(input memop_e op);
      return op inside {MemSb, MemSh, MemSw};
   endfunction

   function automatic logic is_half(input memop_e op);
      return op inside {MemLh, MemLhu, MemSh};
   endfunction

   function automatic logic is_word(input memop_e op);
      return op inside {MemLw, MemSw};
   endfunction

   function automatic logic misaligned(input memop_e op, input logic [1:0] off);
      return (is_half(op) && off[0]) || (is_word(op) && (off != 2'b00));
   endfunction

   function automatic logic [3:0] lane_sel(input memop_e op, input logic [1:0] off);
      logic [3:0] sel;
      sel = 4'b0000;
      if (is_word(op)) begin
         sel = SelWord;
      end else if (is_half(op)) begin
         sel = off[1] ? SelHalfLo : SelHalfHi;
      end else if (op inside {MemLb, MemLbu, MemSb}) begin
         sel = SelByte0 >> off;
      end
      return sel;
   endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane steering: load-side extraction with sign/zero extension,
// or store-side replication of bytes/halfwords across the bus word.
module mem_lane_align
   import mem_lsu_pkg::*;
(
   input  logic        store_i,
   input  memop_e      op_i,
   input  logic [1:0]  off_i,
   input  logic [31:0] data_i,
   output logic [31:0] data_o
);

   logic [7:0]  byte_v;
   logic [15:0] half_v;

   always_comb begin
      byte_v = 8'h00;
      case (off_i)
         2'd0:    byte_v = data_i[31:24];
         2'd1:    byte_v = data_i[23:16];
         2'd2:    byte_v = data_i[15:8];
         default: byte_v = data_i[7:0];
      endcase
      half_v = off_i[1] ? data_i[15:0] : data_i[31:16];

      data_o = data_i;
      if (store_i) begin
         case (op_i)
            MemSb:   data_o = {4{data_i[7:0]}};
            MemSh:   data_o = {2{data_i[15:0]}};
            default: data_o = data_i;
         endcase
      end else begin
         case (op_i)
            MemLb:   data_o = {{24{byte_v[7]}}, byte_v};
            MemLbu:  data_o = {24'h000000, byte_v};
            MemLh:   data_o = {{16{half_v[15]}}, half_v};
            MemLhu:  data_o = {16'h0000, half_v};
            default: data_o = data_i;
         endcase
      end
   end

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: pass-through for non-memory ops, otherwise a
// stalling single-beat bus transfer with alignment and timeout exceptions.
module mem_lsu
   import mem_lsu_pkg::*;
#(
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned REG_ADDR_W  = 5,
   parameter int unsigned ADDR_W      = 32,
   parameter int unsigned TIMEOUT_CYC = 255
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  valid_i,
   input  logic [3:0]            memop_i,
   input  logic [ADDR_W-1:0]     mem_addr_i,
   input  logic [DATA_W-1:0]     mem_sdata_i,
   input  logic [REG_ADDR_W-1:0] wd_i,
   input  logic                  wreg_i,
   input  logic [DATA_W-1:0]     wdata_i,
   input  logic [DATA_W-1:0]     hi_i,
   input  logic [DATA_W-1:0]     lo_i,
   input  logic                  we_i,
   input  logic [DATA_W-1:0]     flags_i,
   output logic                  bus_req_o,
   output logic                  bus_we_o,
   output logic [ADDR_W-1:0]     bus_addr_o,
   output logic [DATA_W/8-1:0]   bus_sel_o,
   output logic [DATA_W-1:0]     bus_wdata_o,
   input  logic [DATA_W-1:0]     bus_rdata_i,
   input  logic                  bus_ack_i,
   output logic [REG_ADDR_W-1:0] wd_o,
   output logic                  wreg_o,
   output logic [DATA_W-1:0]     wdata_o,
   output logic [DATA_W-1:0]     hi_o,
   output logic [DATA_W-1:0]     lo_o,
   output logic                  we_o,
   output logic [DATA_W-1:0]     flags_o,
   output logic                  stallreq_o,
   output logic                  excp_align_o,
   output logic                  excp_bus_o
);

   if (DATA_W != 32) begin : g_bad_data_w
      $error("mem_lsu: only DATA_W == 32 is supported");
   end
   if (TIMEOUT_CYC < 1) begin : g_bad_timeout
      $error("mem_lsu: TIMEOUT_CYC must be at least 1");
   end

   localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);
   localparam int unsigned SelW = DATA_W / 8;

   memop_e          op, op_q, op_d;
   logic [1:0]      off, off_q, off_d;
   lsu_state_e      state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [DATA_W-1:0] rdata_q, rdata_d, wdata_q, wdata_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [SelW-1:0]   sel_q, sel_d;
   logic we_q, we_d, load_q, load_d, tout_q, tout_d;
   logic mem_op, misalign, issue, tout_hit, stall, excp_align;
   logic [DATA_W-1:0] ld_data, st_data;

   assign op  = memop_e'(memop_i);
   assign off = mem_addr_i[1:0];

   // Load path reads the registered op/offset because the pipeline inputs may change under stall.
   mem_lane_align u_ld_align (
      .store_i (1'b0),
      .op_i    (op_q),
      .off_i   (off_q),
      .data_i  (bus_rdata_i),
      .data_o  (ld_data)
   );

   mem_lane_align u_st_align (
      .store_i (1'b1),
      .op_i    (op),
      .off_i   (off),
      .data_i  (mem_sdata_i),
      .data_o  (st_data)
   );

   assign mem_op     = valid_i && (op != MemNone);
   assign misalign   = mem_op && misaligned(op, off);
   // tout_q marks the abort cycle: the timed-out op is still presented and must not reissue.
   assign issue      = (state_q == StIdle) && mem_op && !misalign && !tout_q;
   assign excp_align = (state_q == StIdle) && misalign && !tout_q;
   assign stall      = issue || (state_q == StBusy);
   assign tout_hit   = (state_q == StBusy) && !bus_ack_i && (cnt_q == CntW'(TIMEOUT_CYC - 1));

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rdata_d = rdata_q;
      load_d  = load_q;
      tout_d  = 1'b0;
      addr_d  = addr_q;
      sel_d   = sel_q;
      wdata_d = wdata_q;
      we_d    = we_q;
      op_d    = op_q;
      off_d   = off_q;
      unique case (state_q)
         StIdle: begin
            if (issue) begin
               state_d = StBusy;
               cnt_d   = '0;
               we_d    = is_store(op);
               load_d  = !is_store(op);
               addr_d  = {mem_addr_i[ADDR_W-1:2], 2'b00};
               sel_d   = SelW'(lane_sel(op, off));
               wdata_d = st_data;
               op_d    = op;
               off_d   = off;
            end
         end
         StBusy: begin
            if (bus_ack_i) begin
               state_d = StDone;
               rdata_d = ld_data;
            end else if (tout_hit) begin
               state_d = StIdle;
               tout_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         rdata_q <= '0;
         load_q  <= 1'b0;
         tout_q  <= 1'b0;
         addr_q  <= '0;
         sel_q   <= '0;
         wdata_q <= '0;
         we_q    <= 1'b0;
         op_q    <= MemNone;
         off_q   <= 2'b00;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
         load_q  <= load_d;
         tout_q  <= tout_d;
         addr_q  <= addr_d;
         sel_q   <= sel_d;
         wdata_q <= wdata_d;
         we_q    <= we_d;
         op_q    <= op_d;
         off_q   <= off_d;
      end
   end

   always_comb begin
      wd_o         = wd_i;
      wreg_o       = wreg_i;
      wdata_o      = wdata_i;
      hi_o         = hi_i;
      lo_o         = lo_i;
      we_o         = we_i;
      flags_o      = flags_i;
      bus_req_o    = 1'b0;
      bus_we_o     = 1'b0;
      bus_addr_o   = '0;
      bus_sel_o    = '0;
      bus_wdata_o  = '0;
      stallreq_o   = stall;
      excp_align_o = excp_align;
      excp_bus_o   = tout_q;
      if (state_q == StBusy) begin
         bus_req_o   = 1'b1;
         bus_we_o    = we_q;
         bus_addr_o  = addr_q;
         bus_sel_o   = sel_q;
         bus_wdata_o = wdata_q;
      end
      if (state_q == StDone) begin
         wdata_o = load_q ? rdata_q : wdata_i;
         wreg_o  = wreg_i && load_q;
      end
      if (stall || excp_align || tout_q) begin
         wreg_o = 1'b0;
      end
      if (stall) begin
         we_o = 1'b0;
      end
      if (!rst) begin
         wd_o         = '0;
         wreg_o       = 1'b0;
         wdata_o      = '0;
         hi_o         = '0;
         lo_o         = '0;
         we_o         = 1'b0;
         flags_o      = '0;
         bus_req_o    = 1'b0;
         bus_we_o     = 1'b0;
         bus_addr_o   = '0;
         bus_sel_o    = '0;
         bus_wdata_o  = '0;
         stallreq_o   = 1'b0;
         excp_align_o = 1'b0;
         excp_bus_o   = 1'b0;
      end
   end

endmodule

// File: doc/mem_lsu.md
MEM_LSU -- requirements
Module: mem_lsu

Interface
REQ-001 SHALL have parameter DATA_W, default 32, datapath width; only 32 is supported, and elaboration SHALL fail on any other value.
REQ-002 SHALL have parameter REG_ADDR_W, default 5, width of the register-file write address.
REQ-003 SHALL have parameter ADDR_W, default 32, width of the data-bus address.
REQ-004 SHALL have parameter TIMEOUT_CYC, default 255, maximum number of wait cycles for bus_ack_i before abort.
REQ-005 Ports (name, direction, width, meaning), one per line:
clk  in  1  single clock, all state on rising edge;
rst  in  1  synchronous, active-low reset;
valid_i  in  1  EX/MEM slot holds a live instruction;
memop_i  in  4  NONE/LB/LBU/LH/LHU/LW/SB/SH/SW;
mem_addr_i  in  ADDR_W  effective address;
mem_sdata_i  in  DATA_W  store data;
wd_i  in  REG_ADDR_W  destination register;
wreg_i  in  1  register write enable;
wdata_i  in  DATA_W  ALU result;
hi_i  in  DATA_W  multiply/divide HI;
lo_i  in  DATA_W  multiply/divide LO;
we_i  in  1  HI/LO write enable;
flags_i  in  DATA_W  flags register;
bus_req_o  out  1  bus request;
bus_we_o  out  1  bus write;
bus_addr_o  out  ADDR_W  word-aligned address;
bus_sel_o  out  DATA_W/8  byte-lane enables;
bus_wdata_o  out  DATA_W  lane-replicated store data;
bus_rdata_i  in  DATA_W  read data;
bus_ack_i  in  1  transfer complete;
wd_o, wreg_o, wdata_o, hi_o, lo_o, we_o, flags_o  out  (widths as the inputs)  to write-back;
stallreq_o  out  1  hold the pipeline;
excp_align_o  out  1  misaligned-access pulse;
excp_bus_o  out  1  bus-timeout pulse.

Function
REQ-006 With valid_i=0 or memop_i=NONE, outputs SHALL equal the corresponding inputs combinationally (zero latency), with stallreq_o=0.
REQ-007 The FSM SHALL have states IDLE, BUSY and DONE.
REQ-008 IDLE->BUSY SHALL occur on a valid, aligned memory op; stallreq_o SHALL be 1 combinationally in that IDLE cycle and throughout BUSY.
REQ-009 In BUSY, bus_req_o SHALL be 1 and bus_we_o/addr/sel/wdata SHALL be held stable from registered copies until the cycle in which bus_ack_i=1.
REQ-010 On bus_ack_i in BUSY: SHALL capture the extracted load data, go to DONE, and deassert bus_req_o on the next cycle.
REQ-011 In DONE (one cycle): stallreq_o SHALL be 0, wdata_o SHALL be the captured load data (loads) or wdata_i (stores), and the FSM SHALL go to IDLE; the same memory op SHALL NOT be reissued.
REQ-012 While stallreq_o=1, wreg_o and we_o SHALL be 0.
REQ-013 Byte order SHALL be big-endian: address offset 0 maps to bits [31:24] and bus_sel_o=4'b1000.
REQ-014 Loads: LB/LH SHALL sign-extend and LBU/LHU SHALL zero-extend the selected lane; LW SHALL take the full word.
REQ-015 Stores: SB SHALL replicate the byte to all 4 lanes and SH SHALL replicate the halfword to both halves, with bus_sel_o selecting the target lanes; SW SHALL use sel=4'b1111.
REQ-016 Misalignment (LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0) SHALL issue no bus request, pulse excp_align_o for 1 cycle, force wreg_o=0, and leave stallreq_o at 0.
REQ-017 A wait counter SHALL increment each BUSY cycle without ack.
REQ-018 When the wait counter reaches TIMEOUT_CYC, the block SHALL drop bus_req_o, pulse excp_bus_o, force wreg_o=0, go to IDLE, and clear stall.
REQ-019 A bus_ack_i outside BUSY SHALL be ignored.
REQ-020 An ack in the same cycle as a timeout SHALL win: the transfer completes normally.

Reset
REQ-021 On rst=0 at a clock edge: FSM=IDLE, wait counter=0, captured data=0, and all bus outputs, pulses and stallreq_o SHALL be 0.
REQ-022 While rst=0, wd_o, wreg_o, wdata_o, hi_o, lo_o, we_o and flags_o SHALL be 0.
REQ-023 A reset during BUSY SHALL abandon the transfer; bus_req_o SHALL be low from the first edge sampling rst=0.

Structure
REQ-024 Memop encodings, the state encoding and the lane-select constants SHALL live in the shared defines package.
REQ-025 Lane extraction and replication SHALL be one combinational sub-module, mem_lane_align, instanced twice (load path and store path).

Verification
REQ-026 ALU pass-through: memop=NONE, wdata_i=0x1234_5678 -> same-cycle wdata_o=0x1234_5678, stallreq_o=0.
REQ-027 Load byte: LB at addr 0x101, rdata=0x11F0_2233, ack after 3 wait cycles -> sel=4'b0100, wdata_o=0xFFFF_FFF0 in DONE, stall held 4 cycles.
REQ-028 Store half: SH at addr 0x202, sdata=0xAAAA_BEEF -> bus_wdata_o=0xBEEF_BEEF, sel=4'b0011, wreg_o=0.
REQ-029 Misalignment: LW at addr 0x3 -> excp_align_o 1-cycle pulse, no bus_req_o, wreg_o=0.
REQ-030 Timeout: TIMEOUT_CYC=4, no ack -> excp_bus_o pulse after 4 BUSY cycles, stall released; and with ack on cycle 4 -> normal completion.
REQ-031 Reset abort: rst=0 in BUSY -> bus_req_o=0 and all outputs 0 the next cycle; the next LW completes normally.
